// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed 7-seg scan: one shared 2-bit digit code and one active-low anode per slot.
// All outputs registered (1 cycle after state change); a slot is BLANK_CYCLES dark then SHOW_CYCLES lit.
// No backpressure: a load overwrites the pending buffer and commits at the next frame boundary or while disabled.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SHOW_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [2*NUM_DIGITS-1:0] digits_in,
    output logic                    load_ack,
    output logic [1:0]              digit_value,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_done
);

    localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2*NUM_DIGITS-1:0] active_q, active_d;
    logic [2*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [1:0]              digit_value_q, digit_value_d;
    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
    logic                    load_ack_q, load_ack_d;
    logic                    frame_done_q, frame_done_d;
    logic                    commit;
    logic                    enter_blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BLANK;
            idx_q         <= '0;
            cnt_q         <= '0;
            active_q      <= '0;
            pending_q     <= '0;
            pend_valid_q  <= 1'b0;
            digit_value_q <= '0;
            anodes_q      <= '1;
            load_ack_q    <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            pend_valid_q  <= pend_valid_d;
            digit_value_q <= digit_value_d;
            anodes_q      <= anodes_d;
            load_ack_q    <= load_ack_d;
            frame_done_q  <= frame_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        active_d      = active_q;
        pending_d     = pending_q;
        pend_valid_d  = pend_valid_q;
        digit_value_d = digit_value_q;
        anodes_d      = '1;
        load_ack_d    = 1'b0;
        frame_done_d  = 1'b0;
        commit        = 1'b0;
        enter_blank   = 1'b0;

        if (!enable) begin
            // Parked: dark, rewound to digit 0, and any pending load goes live immediately.
            state_d     = ST_BLANK;
            idx_d       = '0;
            cnt_d       = '0;
            commit      = pend_valid_q;
            enter_blank = 1'b1;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d     = ST_BLANK;
                        cnt_d       = '0;
                        enter_blank = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            idx_d        = '0;
                            frame_done_d = 1'b1;
                            commit       = pend_valid_q;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_BLANK;
            endcase
        end

        if (commit) begin
            active_d     = pending_q;
            pend_valid_d = 1'b0;
            load_ack_d   = 1'b1;
        end
        // A load on the commit edge lands after the commit, so it waits for the next one.
        if (load) begin
            pending_d    = digits_in;
            pend_valid_d = 1'b1;
        end

        if (enter_blank) begin
            digit_value_d = active_d[{idx_d, 1'b0} +: 2];
        end
        if (state_d == ST_SHOW) begin
            anodes_d[idx_d] = 1'b0;
        end
    end

    assign load_ack    = load_ack_q;
    assign digit_value = digit_value_q;
    assign anodes      = anodes_q;
    assign frame_done  = frame_done_q;

endmodule
